hazard_ctrl_unit: RTL

- Parametrised successor to the single-cycle load-use detector in the 5-stage MIPS pipeline.
- Sits between the IF/ID and ID/EX pipeline registers and the PC.
- Generates stall, bubble and flush controls for three hazard sources:
  - load-use with configurable load latency (multi-cycle stall);
  - multiply/divide busy;
  - taken branch/jump redirect from EX.
- Also keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/hazard_ctrl_unit.sv | 132 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use (multi-cycle), mul/div busy and EX redirect.
// Produces PC/IF-ID write enables, ID/EX bubble select and IF/ID flush, plus a
// saturating count of stall cycles.
module hazard_ctrl_unit #(
  parameter int unsigned REG_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_reg_rt,
  input  logic [REG_W-1:0] if_id_reg_rs,
  input  logic [REG_W-1:0] if_id_reg_rt,
  input  logic             if_id_uses_rs,
  input  logic             if_id_uses_rt,
  input  logic             if_id_uses_hilo,
  input  logic             md_busy,
  input  logic             ex_redirect,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             sel_mux_cu,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {StRun, StLdStall, StMdWait} state_e;

  // Remaining load-stall cycles loaded on entry to StLdStall.
  localparam logic [3:0] LatMinusOne = 4'(LOAD_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q;
  logic             lu, mdh, stall;

  // Hazard detection against the instruction currently in ID.
  always_comb begin
    lu  = id_ex_mem_read && (id_ex_reg_rt != '0) &&
          ((if_id_uses_rs && (id_ex_reg_rt == if_id_reg_rs)) ||
           (if_id_uses_rt && (id_ex_reg_rt == if_id_reg_rt)));
    mdh = md_busy && if_id_uses_hilo;
  end

  // Next-state and output decode; redirect overrides any pending stall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    sel_mux_cu  = 1'b0;
    if_id_flush = 1'b0;

    if (ex_redirect) begin
      if_id_flush = 1'b1;
      sel_mux_cu  = 1'b1;
      state_d     = StRun;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (lu) begin
            stall = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = StLdStall;
              cnt_d   = LatMinusOne;
            end
          end else if (mdh) begin
            stall   = 1'b1;
            state_d = StMdWait;
          end
        end
        StLdStall: begin
          stall = 1'b1;
          if (cnt_q <= 4'd1) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        StMdWait: begin
          // First idle cycle of the mul/div unit is already a normal cycle.
          if (md_busy) stall = 1'b1;
          else         state_d = StRun;
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end

    if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      sel_mux_cu  = 1'b1;
    end

    // Reset forces a quiet pipeline regardless of hazards or redirect.
    if (rst) begin
      pc_write    = 1'b1;
      if_id_write = 1'b1;
      sel_mux_cu  = 1'b0;
      if_id_flush = 1'b0;
    end
  end

  // FSM state and load-stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating stall-cycle counter for performance monitoring.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
    end else if (!pc_write && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule
